mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester RAM arbiter: the icache fill port and the dcache port share one RAM port.
// Default build gives data fixed priority; define MEM_ARBITER_RR_EN for round-robin on contention.
module mem_arbiter (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   d_req;

    assign d_req = dREN | dWEN;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MEM_ARBITER_RR_EN
    // Records which side won the most recent contested grant (1 = data).
    // Only contested grants move it, so uncontested traffic does not skew fairness.
    logic last_d_q, last_d_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
`ifdef MEM_ARBITER_RR_EN
        last_d_d = last_d_q;
`endif

        case (state_q)
            IDLE: begin
                if (d_req && iREN) begin
`ifdef MEM_ARBITER_RR_EN
                    if (last_d_q) begin
                        state_d  = IACC;
                        last_d_d = 1'b0;
                    end else begin
                        state_d  = DACC;
                        last_d_d = 1'b1;
                    end
`else
                    state_d = DACC;
`endif
                end else if (d_req) begin
                    state_d = DACC;
                end else if (iREN) begin
                    state_d = IACC;
                end
            end

            IACC: begin
                ramaddr = iaddr;
                if (!iREN) begin
                    state_d = IDLE;
                end else begin
                    ramREN = 1'b1;
                    if (ramready) begin
                        iwait   = 1'b0;
                        iload   = ramload;
                        state_d = IDLE;
                    end
                end
            end

            DACC: begin
                ramaddr  = daddr;
                ramstore = dstore;
                if (!d_req) begin
                    state_d = IDLE;
                end else begin
                    // A simultaneous read and write request is served as a write.
                    ramWEN = dWEN;
                    ramREN = ~dWEN;
                    if (ramready) begin
                        dwait   = 1'b0;
                        state_d = IDLE;
                        if (!dWEN) begin
                            dload = ramload;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // Reset suppresses any completion in the cycle it is asserted.
        if (RST) begin
            state_d  = IDLE;
            iwait    = 1'b1;
            dwait    = 1'b1;
            iload    = '0;
            dload    = '0;
            ramREN   = 1'b0;
            ramWEN   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected completions, a negedge monitor checks them.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ramready;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        is_d;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] load;
    } txn_t;

    txn_t exp_q[$];

    always #5 CLK = ~CLK;

    mem_arbiter dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramready (ramready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic is_d, input logic wen, input logic [31:0] addr,
                        input logic [31:0] store, input logic [31:0] load);
        txn_t t;
        t.is_d  = is_d;
        t.ren   = ~wen;
        t.wen   = wen;
        t.addr  = addr;
        t.store = wen ? store : 32'h0;
        t.load  = load;
        exp_q.push_back(t);
    endtask

    // Monitor: every cycle where a wait is low is one completed transaction.
    always @(negedge CLK) begin
        if (!iwait || !dwait) begin
            txn_t act;
            txn_t e;
            act.is_d  = ~dwait;
            act.ren   = ramREN;
            act.wen   = ramWEN;
            act.addr  = ramaddr;
            act.store = ramWEN ? ramstore : 32'h0;
            act.load  = dwait ? iload : dload;
            n_cmp++;
            if (!iwait && !dwait) begin
                n_bad++;
                $display("FAIL dual_complete: got iwait=0 dwait=0 expected one side only");
            end else if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_complete: got %s completion expected none",
                         act.is_d ? "data" : "instr");
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    n_bad++;
                    $display("FAIL txn: got d=%0b r=%0b w=%0b a=%08h s=%08h l=%08h expected d=%0b r=%0b w=%0b a=%08h s=%08h l=%08h",
                             act.is_d, act.ren, act.wen, act.addr, act.store, act.load,
                             e.is_d, e.ren, e.wen, e.addr, e.store, e.load);
                end else begin
                    $display("ok   txn %s addr=%08h load=%08h", act.is_d ? "D" : "I", act.addr, act.load);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        logic first_d;
        logic second_d;

        RST = 1'b1; iREN = 0; iaddr = 0; dREN = 0; dWEN = 0; daddr = 0; dstore = 0;
        ramload = 0; ramready = 0;

        // Reset state, with ramready high in IDLE ignored.
        tick(); tick();
        RST = 1'b0; ramready = 1'b1;
        chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
        chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
        chk("rst_iwait",  {31'd0, iwait},  32'd1);
        chk("rst_dwait",  {31'd0, dwait},  32'd1);
        chk("rst_iload",  iload, 32'd0);
        chk("rst_dload",  dload, 32'd0);
        tick();
        chk("idle_ready_dwait", {31'd0, dwait}, 32'd1);
        ramready = 1'b0;

        // Instruction fill, RAM ready on the second grant cycle.
        iREN = 1; iaddr = 32'h40;
        push(1'b0, 1'b0, 32'h40, 32'h0, 32'h8C220004);
        chk("ifill_idle_ren", {31'd0, ramREN}, 32'd0);
        tick();
        chk("ifill_wait_ren", {31'd0, ramREN}, 32'd1);
        chk("ifill_wait_addr", ramaddr, 32'h40);
        chk("ifill_wait_iwait", {31'd0, iwait}, 32'd1);
        ramready = 1; ramload = 32'h8C220004;
        tick();
        iREN = 0; ramready = 0; ramload = 32'h0;
        chk("ifill_after_ren", {31'd0, ramREN}, 32'd0);
        tick();

        // Data write, RAM ready on the first grant cycle.
        dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramload = 32'h55555555;
        push(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0);
        tick();
        ramready = 1;
        chk("dwr_wen", {31'd0, ramWEN}, 32'd1);
        tick();
        dWEN = 0; ramready = 0;
        chk("dwr_after_dwait", {31'd0, dwait}, 32'd1);
        chk("dwr_after_wen", {31'd0, ramWEN}, 32'd0);
        tick();

        // Read and write together behave as a write.
        dREN = 1; dWEN = 1; daddr = 32'h104; dstore = 32'h12345678;
        push(1'b1, 1'b1, 32'h104, 32'h12345678, 32'h0);
        tick();
        ramready = 1;
        tick();
        dREN = 0; dWEN = 0; ramready = 0;
        tick();

        // Fresh arbitration state before the contention test.
        RST = 1; tick(); RST = 0;

        // Two simultaneous pairs, RAM always ready.
        ramready = 1; ramload = 32'hA5A5_0001;
        for (int p = 0; p < 2; p++) begin
`ifdef MEM_ARBITER_RR_EN
            first_d = (p == 0);
`else
            first_d = 1'b1;
`endif
            second_d = ~first_d;
            iREN = 1; dREN = 1; iaddr = 32'h80 + p; daddr = 32'h200 + p;
            push(first_d,  1'b0, first_d  ? 32'h200 + p : 32'h80 + p, 32'h0, 32'hA5A5_0001);
            push(second_d, 1'b0, second_d ? 32'h200 + p : 32'h80 + p, 32'h0, 32'hA5A5_0001);
            tick();
            tick();
            if (first_d) dREN = 0; else iREN = 0;
            chk("pair_gap_ren", {31'd0, ramREN}, 32'd0);
            tick();
            tick();
            iREN = 0; dREN = 0;
            tick();
        end
        ramready = 0;

        // Reset during a stalled data read.
        dREN = 1; daddr = 32'h300;
        tick();
        chk("drd_stall_ren", {31'd0, ramREN}, 32'd1);
        RST = 1;
        tick();
        RST = 0; dREN = 0;
        chk("drd_rst_ren", {31'd0, ramREN}, 32'd0);
        chk("drd_rst_dwait", {31'd0, dwait}, 32'd1);
        tick();

        // Instruction request withdrawn before RAM is ready.
        iREN = 1; iaddr = 32'h44;
        tick();
        chk("iabort_ren_on", {31'd0, ramREN}, 32'd1);
        iREN = 0;
        #1;
        chk("iabort_ren_drop", {31'd0, ramREN}, 32'd0);
        chk("iabort_iwait", {31'd0, iwait}, 32'd1);
        ramready = 1;
        tick();
        chk("iabort_idle_ren", {31'd0, ramREN}, 32'd0);
        ramready = 0;
        tick(); tick();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
